// File: rtl/bcd_display_pkg.sv
// Shared constants and helpers for the three-digit BCD seven-segment driver.
// Segment bit order is {g,f,e,d,c,b,a}, active high.
package bcd_display_pkg;

   localparam int NUM_DIGITS = 3;

   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Standard decimal glyphs, indexed by digit value.
   localparam logic [6:0] SEG_DIGITS [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   // Digit positions on the common bus; an[0] drives the ones digit.
   typedef enum logic [1:0] {
      DIG_ONES     = 2'd0,
      DIG_TENS     = 2'd1,
      DIG_HUNDREDS = 2'd2
   } digit_e;

   // A nibble outside 0..9 is not a decimal digit.
   function automatic logic nibble_invalid(input logic [3:0] nib);
      return (nib > 4'd9);
   endfunction

   // True when any nibble of a packed three-digit word is non-decimal.
   function automatic logic word_has_err(input logic [11:0] word);
      return nibble_invalid(word[11:8]) |
             nibble_invalid(word[7:4])  |
             nibble_invalid(word[3:0]);
   endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// Combinational nibble to seven-segment decoder. Decimal values map to the
// standard glyphs; anything above 9 shows a dash so bad data is visible.
module bcd_seg_decoder
   import bcd_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Glyph lookup with dash fallback for non-decimal nibbles.
   always_comb begin
      seg = SEG_DASH;
      if (nibble <= 4'd9) begin
         seg = SEG_DIGITS[nibble];
      end else begin
         seg = SEG_DASH;
      end
   end

endmodule

// File: rtl/bcd_display_driver.sv
// Multiplexed three-digit seven-segment driver. A new BCD word is taken via
// valid/ready into a one-deep pending buffer and only moved to the displayed
// register at the end of a frame, so a frame never mixes two words. Leading
// zeros are blanked, the first cycle of every digit slot is a dark guard
// cycle against ghosting, and seg/an come straight from flops.
module bcd_display_driver
   import bcd_display_pkg::*;
#(
   parameter int unsigned CLK_DIV = 1000
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [11:0]           bcd_in,
   input  logic                  bcd_valid,
   output logic                  bcd_ready,
   output logic [6:0]            seg,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  bcd_err,
   output logic                  frame_done
);

   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0]      cnt_r;
   digit_e                digit_r;
   digit_e                digit_next_s;
   logic [11:0]           pending_r;
   logic                  pending_full_r;
   logic [11:0]           disp_r;
   logic [6:0]            seg_r;
   logic [NUM_DIGITS-1:0] an_r;
   logic                  bcd_err_r;
   logic                  frame_done_r;

   logic                  cnt_last_s;
   logic                  wrap_s;
   logic                  capture_s;
   logic                  commit_s;
   logic [3:0]            nibble_s;
   logic                  blank_s;
   logic [NUM_DIGITS-1:0] an_sel_s;
   logic [6:0]            dec_seg_s;
   logic [6:0]            seg_next_s;
   logic [NUM_DIGITS-1:0] an_next_s;

   assign cnt_last_s = (cnt_r == CNT_LAST);
   assign wrap_s     = cnt_last_s && (digit_r == DIG_HUNDREDS);
   assign capture_s  = bcd_valid && !pending_full_r;
   // Capture needs an empty buffer and commit needs a full one, so they
   // can never fire in the same cycle.
   assign commit_s   = wrap_s && pending_full_r;

   assign bcd_ready  = !pending_full_r;
   assign seg        = seg_r;
   assign an         = an_r;
   assign bcd_err    = bcd_err_r;
   assign frame_done = frame_done_r;

   // Per-digit dwell counter, 0..CLK_DIV-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_last_s) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Digit scan state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_r <= DIG_ONES;
      end else begin
         digit_r <= digit_next_s;
      end
   end

   // Digit scan next state: advance ones -> tens -> hundreds -> ones.
   always_comb begin
      digit_next_s = digit_r;
      if (cnt_last_s) begin
         case (digit_r)
            DIG_ONES:     digit_next_s = DIG_TENS;
            DIG_TENS:     digit_next_s = DIG_HUNDREDS;
            DIG_HUNDREDS: digit_next_s = DIG_ONES;
            default:      digit_next_s = DIG_ONES;
         endcase
      end else begin
         digit_next_s = digit_r;
      end
   end

   // Pending buffer: fill on handshake, empty on frame-boundary commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r      <= 12'h000;
         pending_full_r <= 1'b0;
      end else if (capture_s) begin
         pending_r      <= bcd_in;
         pending_full_r <= 1'b1;
      end else if (commit_s) begin
         pending_full_r <= 1'b0;
      end
   end

   // Displayed word and its error flag change together only at commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_r    <= 12'h000;
         bcd_err_r <= 1'b0;
      end else if (commit_s) begin
         disp_r    <= pending_r;
         bcd_err_r <= word_has_err(pending_r);
      end
   end

   // End-of-frame strobe, lands on the same cycle the new word is visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done_r <= 1'b0;
      end else begin
         frame_done_r <= wrap_s;
      end
   end

   // Select the active nibble, its enable bit and leading-zero blanking.
   // Non-decimal nibbles are non-zero, so they are never blanked.
   always_comb begin
      nibble_s = 4'h0;
      blank_s  = 1'b1;
      an_sel_s = 3'b000;
      case (digit_r)
         DIG_ONES: begin
            nibble_s = disp_r[3:0];
            blank_s  = 1'b0;
            an_sel_s = 3'b001;
         end
         DIG_TENS: begin
            nibble_s = disp_r[7:4];
            blank_s  = (disp_r[11:8] == 4'h0) && (disp_r[7:4] == 4'h0);
            an_sel_s = 3'b010;
         end
         DIG_HUNDREDS: begin
            nibble_s = disp_r[11:8];
            blank_s  = (disp_r[11:8] == 4'h0);
            an_sel_s = 3'b100;
         end
         default: begin
            nibble_s = 4'h0;
            blank_s  = 1'b1;
            an_sel_s = 3'b000;
         end
      endcase
   end

   bcd_seg_decoder u_dec (
      .nibble (nibble_s),
      .seg    (dec_seg_s)
   );

   // Output pattern: dark guard on cnt==0, blank glyph keeps its enable.
   always_comb begin
      seg_next_s = SEG_BLANK;
      an_next_s  = 3'b000;
      if (cnt_r == {CNT_W{1'b0}}) begin
         seg_next_s = SEG_BLANK;
         an_next_s  = 3'b000;
      end else if (blank_s) begin
         seg_next_s = SEG_BLANK;
         an_next_s  = an_sel_s;
      end else begin
         seg_next_s = dec_seg_s;
         an_next_s  = an_sel_s;
      end
   end

   // Output register stage for glitch-free pad drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_r <= SEG_BLANK;
         an_r  <= 3'b000;
      end else begin
         seg_r <= seg_next_s;
         an_r  <= an_next_s;
      end
   end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Self-checking bench for bcd_display_driver with CLK_DIV=4 (12-cycle frame).
// A reference model derives the expected outputs from elapsed time since
// reset and the display rules; directed frames also check literal glyphs.
module tb_bcd_display_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] bcd_in;
   logic        bcd_valid;
   logic        bcd_ready;
   logic [6:0]  seg;
   logic [2:0]  an;
   logic        bcd_err;
   logic        frame_done;

   int tests = 0;
   int fails = 0;

   // Reference model state
   int          m_t;
   logic        m_full;
   logic [11:0] m_pend;
   logic [11:0] m_disp;
   logic        m_err;
   logic [6:0]  e_seg;
   logic [2:0]  e_an;
   logic        e_fd;

   bcd_display_driver #(.CLK_DIV(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bcd_in     (bcd_in),
      .bcd_valid  (bcd_valid),
      .bcd_ready  (bcd_ready),
      .seg        (seg),
      .an         (an),
      .bcd_err    (bcd_err),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
         4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
         4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   // Expected glyph for digit position d (0=ones) of word w.
   function automatic logic [6:0] ref_seg(input int d, input logic [11:0] w);
      logic [3:0] h, t, o;
      h = w[11:8]; t = w[7:4]; o = w[3:0];
      if (d == 2) return (h == 4'd0) ? 7'h00 : glyph(h);
      if (d == 1) return (h == 4'd0 && t == 4'd0) ? 7'h00 : glyph(t);
      return glyph(o);
   endfunction

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: advance the model, then compare all outputs #1 after the edge.
   task automatic step();
      int p, d, c;
      @(posedge clk);
      if (!rst_n) begin
         m_t = 0; m_full = 1'b0; m_disp = 12'h000; m_err = 1'b0;
         e_seg = 7'h00; e_an = 3'b000; e_fd = 1'b0;
      end else begin
         p = m_t % 12; d = p / 4; c = p % 4;
         e_an  = (c == 0) ? 3'b000 : 3'(1 << d);
         e_seg = (c == 0) ? 7'h00 : ref_seg(d, m_disp);
         e_fd  = (p == 11);
         if (p == 11 && m_full) begin
            m_disp = m_pend;
            m_full = 1'b0;
            m_err  = (m_pend[11:8] > 4'd9) || (m_pend[7:4] > 4'd9) || (m_pend[3:0] > 4'd9);
         end else if (bcd_valid && !m_full) begin
            m_pend = bcd_in;
            m_full = 1'b1;
         end
         m_t++;
      end
      #1;
      chk("seg", {5'd0, seg}, {5'd0, e_seg});
      chk("an", {9'd0, an}, {9'd0, e_an});
      chk("frame_done", {11'd0, frame_done}, {11'd0, e_fd});
      chk("bcd_err", {11'd0, bcd_err}, {11'd0, m_err});
      chk("bcd_ready", {11'd0, bcd_ready}, {11'd0, !m_full});
   endtask

   // Run until the pending word has committed and a frame is about to start.
   task automatic wait_commit();
      int n = 0;
      while (!(m_full == 1'b0 && (m_t % 12) == 0) && n < 40) begin
         step();
         n++;
      end
      chk("commit_timeout", {11'd0, (n < 40)}, 12'd1);
   endtask

   // Check one whole frame against literal glyphs for ones/tens/hundreds.
   task automatic expect_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
      logic [6:0] xs;
      logic [2:0] xa;
      for (int i = 0; i < 12; i++) begin
         step();
         if (i % 4 == 0) begin
            xs = 7'h00; xa = 3'b000;
         end else begin
            xa = 3'(1 << (i / 4));
            xs = (i / 4 == 0) ? s0 : ((i / 4 == 1) ? s1 : s2);
         end
         chk("frame_seg", {5'd0, seg}, {5'd0, xs});
         chk("frame_an", {9'd0, an}, {9'd0, xa});
      end
   endtask

   task automatic offer(input logic [11:0] w);
      bcd_in = w; bcd_valid = 1'b1;
      step();
      bcd_valid = 1'b0;
      chk("ready_after_capture", {11'd0, bcd_ready}, 12'd0);
   endtask

   initial begin
      rst_n = 1'b0; bcd_in = 12'h000; bcd_valid = 1'b0;
      m_t = 0; m_full = 1'b0; m_pend = 12'h000; m_disp = 12'h000; m_err = 1'b0;
      step(); step();
      chk("rst_seg", {5'd0, seg}, 12'd0);
      chk("rst_an", {9'd0, an}, 12'd0);
      chk("rst_ready", {11'd0, bcd_ready}, 12'd1);
      @(negedge clk) rst_n = 1'b1;

      // Reset shows "0" on the ones digit only
      wait_commit();
      expect_frame(7'h3F, 7'h00, 7'h00);

      // 255
      offer(12'h255);
      wait_commit();
      expect_frame(7'h6D, 7'h6D, 7'h5B);
      chk("ready_back", {11'd0, bcd_ready}, 12'd1);

      // Leading-zero blanking
      offer(12'h007);
      wait_commit();
      expect_frame(7'h07, 7'h00, 7'h00);
      offer(12'h070);
      wait_commit();
      expect_frame(7'h3F, 7'h07, 7'h00);

      // Invalid nibble, then cleared
      offer(12'h1A3);
      wait_commit();
      expect_frame(7'h4F, 7'h40, 7'h06);
      chk("err_set", {11'd0, bcd_err}, 12'd1);
      offer(12'h123);
      wait_commit();
      expect_frame(7'h4F, 7'h5B, 7'h06);
      chk("err_clr", {11'd0, bcd_err}, 12'd0);

      // Backpressure: 222 held while 111 waits, accepted right after commit
      bcd_in = 12'h111; bcd_valid = 1'b1;
      step();
      bcd_in = 12'h222;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_ready_low", {11'd0, bcd_ready}, 12'd0);
      end
      wait_commit();
      expect_frame(7'h06, 7'h06, 7'h06);
      bcd_valid = 1'b0;
      wait_commit();
      expect_frame(7'h5B, 7'h5B, 7'h5B);

      // Mid-frame reset during digit 1 with a word pending
      offer(12'h999);
      for (int i = 0; i < 5; i++) step();
      chk("pre_rst_pending", {11'd0, bcd_ready}, 12'd0);
      chk("pre_rst_digit1", {9'd0, an}, 12'd2);
      rst_n = 1'b0;
      #1;
      chk("async_seg", {5'd0, seg}, 12'd0);
      chk("async_an", {9'd0, an}, 12'd0);
      chk("async_fd", {11'd0, frame_done}, 12'd0);
      chk("async_err", {11'd0, bcd_err}, 12'd0);
      chk("async_ready", {11'd0, bcd_ready}, 12'd1);
      step(); step();
      @(negedge clk) rst_n = 1'b1;
      wait_commit();
      expect_frame(7'h3F, 7'h00, 7'h00);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         bcd_valid = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 0) begin
            bcd_in = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
         end else begin
            bcd_in = {4'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 9)),
                      4'($urandom_range(0, 1) == 0 ? 0 : $urandom_range(0, 9)),
                      4'($urandom_range(0, 9))};
         end
         step();
      end
      bcd_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Guard against a hung run
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bcd_display_driver.md
# bcd_display_driver

Multiplexed three-digit seven-segment driver that consumes the 12-bit packed BCD word from the binary-to-BCD conversion stage and scans it onto a common-bus LED display. Accepts a new value through a valid/ready handshake and buffers it in a pending register. Commits the value only at a frame boundary so a displayed frame never tears. Applies leading-zero blanking, shows a dash for non-decimal nibbles, and inserts a one-cycle ghosting guard at every digit change.

## Interface
- CLK_DIV, default 1000: clock cycles each digit is driven; legal range 2..65535.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bcd_in  in  12  packed BCD, {hundreds[11:8], tens[7:4], ones[3:0]}.
- bcd_valid  in  1  upstream has a word on bcd_in (conversion-done strobe or level).
- bcd_ready  out  1  pending buffer empty; combinational, equal to !pending_full.
- seg  out  7  active-high segments {g,f,e,d,c,b,a}, registered.
- an  out  3  one-hot active-high digit enable (an[0]=ones), registered.
- bcd_err  out  1  high while the committed word holds any nibble > 9.
- frame_done  out  1  one-cycle pulse when digit 2 finishes.

## Operation
- Capture: on bcd_valid && bcd_ready, bcd_in → pending and pending_full ← 1. Words offered while bcd_ready=0 are not taken, and upstream holds them.
- Commit: on the cycle the scan wraps from digit 2 to digit 0 with pending_full=1, pending → disp and pending_full ← 0. bcd_ready rises the next cycle.
- Capture and commit never coincide, because capture requires pending_full=0 and commit requires pending_full=1.
- Scan: divider cnt runs 0..CLK_DIV-1. At CLK_DIV-1, cnt ← 0 and digit advances 0→1→2→0.
- The frame_done pulse is registered and asserts the cycle after the 2→0 wrap, aligned with the commit.
- Decode: the digit select picks a nibble of disp, and bcd_seg_decoder maps it:
  - 0..9 → standard patterns (for example 0=7'h3F, 1=7'h06, 8=7'h7F).
  - 10..15 → dash, 7'h40.
- Leading-zero blanking:
  - hundreds blank when its nibble is 0;
  - tens blank when hundreds==0 and tens==0;
  - ones never blanked.
  - An invalid nibble counts as non-zero.
  - A blanked digit drives seg=0, but its an bit is still asserted.
- Ghost guard: while cnt==0, an=3'b000 and seg=0.
- bcd_err is recomputed from disp on every commit and held until the next commit.

## Timing
- Reset (async assert, sync release): cnt=0, digit=0, disp=0, pending_full=0.
- Output reset values: seg=0, an=0, bcd_err=0, frame_done=0, bcd_ready=1.
- Display after reset shows "0" on the ones digit.
- Output latency: seg/an reflect the cnt/digit/disp state of the previous cycle, one register stage.
- Digit on-time is CLK_DIV-1 lit cycles plus 1 guard cycle. Frame length is 3·CLK_DIV cycles.
- Worst-case input-to-display latency is 3·CLK_DIV+2 cycles.
- Back-to-back words: the second waits until the first commits, giving at most one accepted word per frame.
- Reset mid-frame: pending is discarded and the scan restarts at digit 0, cnt 0.

## Structure
- Package bcd_display_pkg holds:
  - NUM_DIGITS=3;
  - SEG_DASH=7'h40 and SEG_BLANK=7'h00;
  - the ten digit patterns as a localparam array.
- Sub-module bcd_seg_decoder: combinational, 4-bit nibble in, 7-bit seg out; handles dash for 10..15.
- Top level holds the divider, digit counter, pending/disp registers, blanking logic and output registers.

## Test plan
All scenarios use CLK_DIV=4, so one frame is 12 cycles.
- Reset: hold rst_n=0, then release → seg=0, an=0, bcd_ready=1.
  - First frame: ones digit shows 7'h3F; tens and hundreds have seg=0 while their an bit is high.
- Value 12'h255 (for example upstream 255):
  - bcd_ready falls the cycle after capture.
  - At the next wrap, the frame shows an=001 seg=7'h6D, an=010 seg=7'h6D, an=100 seg=7'h5B.
  - bcd_ready returns to 1.
- Leading zeros, value 12'h007:
  - hundreds and tens have seg=0 while their an is high;
  - ones shows 7'h07.
  - For 12'h070, tens shows 7'h07 and ones shows 7'h3F.
- Invalid value 12'h1A3:
  - tens shows 7'h40 and bcd_err=1 after commit.
  - A following 12'h123 clears bcd_err at its commit.
- Backpressure:
  - Hold bcd_valid with 12'h111, then 12'h222 → the second word stays unaccepted while bcd_ready=0.
  - 12'h222 is accepted the cycle after the first commit.
  - 12'h222 displays one frame after 12'h111; no frame mixes digits of the two.
- Ghost guard and mid-frame reset:
  - Check that an=000 on every cnt==0 cycle.
  - Assert rst_n low during digit 1 with pending_full=1 → all outputs clear immediately, pending is lost, and "0" is displayed after release.
